// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled by defining LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int FRAME_HDR_BYTES = 2;
    localparam int BYTES_PER_WORD  = 4;

    // Lane index counts accepted bytes within the word being assembled.
    localparam logic [1:0] LANE_FIRST = 2'd0;
    localparam logic [1:0] LANE_LAST  = 2'(BYTES_PER_WORD - 1);

    // Big-endian packing: earlier bytes drift toward [31:24].
    function automatic logic [31:0] shift_in_byte(input logic [31:0] w, input logic [7:0] b);
        return {w[23:0], b};
    endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Shift-in byte register with a lane counter; word/word_full show the
// packed word as it will look once the current byte is accepted.
import imem_loader_pkg::*;

module imem_loader_byte_word_packer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] word_q;
    logic [1:0]  lane_q;

    assign word      = shift_in_byte(word_q, byte_in);
    assign word_full = shift_en && (lane_q == LANE_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            word_q <= '0;
            lane_q <= LANE_FIRST;
        end else if (clr) begin
            word_q <= '0;
            lane_q <= LANE_FIRST;
        end else if (shift_en) begin
            word_q <= word;
            lane_q <= lane_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: length header, big-endian word
// packing, sequential word writes. Checksum trailer under LOADER_CHECKSUM_EN.
import imem_loader_pkg::*;

module imem_loader #(
    parameter int ADDR_W     = 10,
    parameter int MAX_WORDS  = 256,
    parameter int START_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [15:0]       MAX_N   = 16'(MAX_WORDS);

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] len_q;
    logic [15:0] len_in;
    logic        xfer;
    logic        start_ok;
    logic [31:0] pk_word;
    logic        pk_full;
    logic [ADDR_W-1:0] next_addr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer      = byte_valid && byte_ready;
    assign len_in    = {len_hi, byte_in};
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    // Modulo-2**ADDR_W word address; legal lengths never reach the wrap.
    assign next_addr = START_A + {word_count[ADDR_W-3:0], 2'b00};

    imem_loader_byte_word_packer u_packer (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr       (start_ok),
        .shift_en  (xfer && state == S_DATA),
        .byte_in   (byte_in),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= START_A;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            len_hi     <= '0;
            len_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ok) begin
                        state      <= S_LEN_HI;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= byte_in;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q <= len_in;
                        if (len_in == 16'd0) begin
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            cpu_hold   <= 1'b0;
                            done       <= 1'b1;
                        end else if (len_in > MAX_N) begin
                            // CPU stays held on a rejected load.
                            state      <= S_ERR;
                            byte_ready <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_in;
`endif
                        if (pk_full) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            wr_en      <= 1'b1;
                            wr_addr    <= next_addr;
                            wr_data    <= pk_word;
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + 16'd1;
                    if (word_count + 16'd1 < len_q) begin
                        state      <= S_DATA;
                        byte_ready <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state      <= S_CSUM;
                        byte_ready <= 1'b1;
`else
                        state      <= S_DONE;
                        cpu_hold   <= 1'b0;
                        done       <= 1'b1;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_in == csum) begin
                            state    <= S_DONE;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W=10, MAX_WORDS=256, START_ADDR=0).
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic        wh_q[$];

    imem_loader #(.ADDR_W(10), .MAX_WORDS(256), .START_ADDR(0)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 CLK = ~CLK;

    // Log every write strobe (and the hold level during it) away from the edge.
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wh_q.push_back(cpu_hold);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wh_q.delete();
    endtask

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
        byte_valid = 1'b1;
        byte_in    = b;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge CLK);
            rdy = byte_ready;
            @(posedge CLK);
            #1;
            n++;
        end
        byte_valid = 1'b0;
        byte_in    = 8'hxx;
        if (!rdy) chk("xfer_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_finish_in_time"}, 32'(n < 100), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic send_trailer(input logic [7:0] c, input int gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(c, gap);
`else
        if (c === 8'hzz) send_byte(c, gap);
`endif
    endtask

    task automatic send_frame1(input int gap);
        logic [7:0] fr [10];
        fr = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h10, 8'h20, 8'h01, 8'h27, 8'h40, 8'h25};
        for (int i = 0; i < 10; i++) send_byte(fr[i], gap);
        // XOR of the eight payload bytes is 8'h72.
        send_trailer(8'h72, gap);
    endtask

    task automatic check_frame1(input string tag);
        chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk({tag, "_addr0"}, 32'(wa_q[0]), 32'd0);
            chk({tag, "_data0"}, wd_q[0], 32'h00011020);
            chk({tag, "_addr1"}, 32'(wa_q[1]), 32'd4);
            chk({tag, "_data1"}, wd_q[1], 32'h01274025);
            chk({tag, "_hold_at_last_wr"}, 32'(wh_q[1]), 32'd1);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd2);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        RESET      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("reset");
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // 1: basic two-word load with a latency check on the first word
        clear_log();
        pulse_start();
        chk("t1_hold_after_start", 32'(cpu_hold), 32'd1);
        chk("t1_ready_after_start", 32'(byte_ready), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        chk("t1_wr_en_latency", 32'(wr_en), 32'd1);
        chk("t1_ready_in_write", 32'(byte_ready), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h27, 0);
        send_byte(8'h40, 0);
        send_byte(8'h25, 0);
        send_trailer(8'h72, 0);
        wait_end("t1");
        check_frame1("t1");

        // 2: same frame, valid only one cycle in three
        clear_log();
        pulse_start();
        send_frame1(2);
        wait_end("t2");
        check_frame1("t2");

        // 3a: zero-length frame
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_end("t3a");
        chk("t3a_nwrites", 32'(wa_q.size()), 32'd0);
        chk("t3a_done", 32'(done), 32'd1);
        chk("t3a_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("t3a_word_count", 32'(word_count), 32'd0);

        // 3b: length MAX_WORDS+1 = 257
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        wait_end("t3b");
        repeat (3) @(posedge CLK);
        #1;
        chk("t3b_nwrites", 32'(wa_q.size()), 32'd0);
        chk("t3b_err", 32'(err), 32'd1);
        chk("t3b_done", 32'(done), 32'd0);
        chk("t3b_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t3b_byte_ready", 32'(byte_ready), 32'd0);

        // 4: reset after two payload bytes, then a clean reload
        clear_log();
        pulse_start();
        chk("t4_err_cleared", 32'(err), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        byte_valid = 1'b1;
        byte_in    = 8'h10;
        #2;
        RESET = 1'b1;
        #1;
        check_reset_vals("t4_async");
        repeat (3) @(posedge CLK);
        #1;
        byte_valid = 1'b0;
        chk("t4_nwrites_in_reset", 32'(wa_q.size()), 32'd0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk("t4_idle_ready", 32'(byte_ready), 32'd0);
        pulse_start();
        send_frame1(0);
        wait_end("t4");
        check_frame1("t4");

        // 5: start pulsed mid-DATA must be ignored
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        pulse_start();
        chk("t5_busy_after_start", 32'(cpu_hold), 32'd1);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        send_byte(8'h01, 0);
        send_byte(8'h27, 0);
        send_byte(8'h40, 0);
        send_byte(8'h25, 0);
        send_trailer(8'h72, 0);
        wait_end("t5");
        check_frame1("t5");

`ifdef LOADER_CHECKSUM_EN
        // 6: bad checksum byte aborts but keeps the written words
        clear_log();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] fr [10];
            fr = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h10, 8'h20, 8'h01, 8'h27, 8'h40, 8'h25};
            send_byte(fr[i], 0);
        end
        send_byte(8'h00, 0);
        wait_end("t6");
        chk("t6_nwrites", 32'(wa_q.size()), 32'd2);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_cpu_hold", 32'(cpu_hold), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
